mywcfifo_8to16: RTL and testbench

Single-clock, width-expanding FIFO: accepts 8-bit bytes on the write side and delivers 16-bit words on the read side, packing byte pairs low-byte-first. It is the inverse-ratio companion of the 16-in/8-out dual-clock FIFO. It sits at the front of byte-serial capture paths and feeds the 16-bit processing datapath.

---
 rtl/mywcfifo_pkg.sv | 23 ++
 rtl/mywcfifo_8to16_if.sv | 24 ++
 rtl/sdpram_16.sv | 30 +++
 rtl/mywcfifo_8to16.sv | 118 +++++++++++
 tb/tb_mywcfifo_8to16.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/mywcfifo_pkg.sv
// Shared widths, pointer/count types and word packing for the 8-to-16 width-expanding FIFO.
package mywcfifo_pkg;

  localparam int unsigned WORD_DEPTH = 256;
  localparam int unsigned ADDR_W     = $clog2(WORD_DEPTH);
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_W     = 16;
  localparam int unsigned PTR_W      = ADDR_W + 1;
  localparam int unsigned BCNT_W     = ADDR_W + 2;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [PTR_W-1:0]  ptr_t;
  typedef logic [PTR_W-1:0]  wcount_t;
  typedef logic [BCNT_W-1:0] bcount_t;
  typedef logic [BYTE_W-1:0] byte_t;
  typedef logic [WORD_W-1:0] word_t;

  // First-written byte lands in the low half of the word.
  function automatic word_t pack_word(input byte_t hi, input byte_t lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/mywcfifo_8to16_if.sv
// Byte-write / word-read bus of the 8-to-16 FIFO; master drives requests, slave is the FIFO.
interface mywcfifo_8to16_if;
  import mywcfifo_pkg::*;

  byte_t   data;
  logic    wrreq;
  logic    rdreq;
  word_t   q;
  logic    rdempty;
  logic    wrfull;
  wcount_t rdusedw;
  bcount_t wrusedw;

  modport master (
    output data, wrreq, rdreq,
    input  q, rdempty, wrfull, rdusedw, wrusedw
  );

  modport slave (
    input  data, wrreq, rdreq,
    output q, rdempty, wrfull, rdusedw, wrusedw
  );

endinterface

// File: rtl/sdpram_16.sv
// Simple dual-port synchronous RAM, 16-bit words: one write port, one read port, registered read data.
module sdpram_16
  import mywcfifo_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_wr_en,
  input  addr_t i_wr_addr,
  input  word_t i_wr_data,
  input  logic  i_rd_en,
  input  addr_t i_rd_addr,
  output word_t o_rd_data
);

  word_t r_mem [WORD_DEPTH];
  word_t r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Same-address read during write returns the old contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/mywcfifo_8to16.sv
// Single-clock FIFO packing byte pairs (low byte first) into 16-bit words.
// Define FIFO_SHOWAHEAD_EN for a look-ahead output where q presents the head word without a read.
module mywcfifo_8to16
  import mywcfifo_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  mywcfifo_8to16_if.slave  bus
);

  ptr_t    r_wr_ptr, r_rd_ptr;
  logic    r_half;
  byte_t   r_lo_byte;
  word_t   r_q;
  logic    r_rdempty, r_wrfull;
  wcount_t r_rdusedw;
  bcount_t r_wrusedw;

  logic    w_wr_acc, w_rd_acc, w_word_wr, w_half_nxt;
  ptr_t    w_wr_ptr_nxt, w_rd_ptr_nxt;
  wcount_t w_words_nxt;
  bcount_t w_bytes_nxt;
  word_t   w_wr_word, w_ram_rd_data;
  logic    w_ram_rd_en;
  addr_t   w_ram_rd_addr;

  // Acceptance uses the registered flags, so a full FIFO never writes and an empty one never reads.
  always_comb begin
    w_wr_acc     = bus.wrreq && !r_wrfull;
    w_rd_acc     = bus.rdreq && !r_rdempty;
    w_word_wr    = w_wr_acc && r_half;
    w_half_nxt   = w_wr_acc ? !r_half : r_half;
    w_wr_ptr_nxt = w_word_wr ? r_wr_ptr + PTR_W'(1) : r_wr_ptr;
    w_rd_ptr_nxt = w_rd_acc  ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;
    w_words_nxt  = wcount_t'(w_wr_ptr_nxt - w_rd_ptr_nxt);
    w_bytes_nxt  = {w_words_nxt, w_half_nxt};
    w_wr_word    = pack_word(bus.data, r_lo_byte);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_half    <= 1'b0;
      r_lo_byte <= '0;
      r_rdempty <= 1'b1;
      r_wrfull  <= 1'b0;
      r_rdusedw <= '0;
      r_wrusedw <= '0;
    end else begin
      r_wr_ptr  <= w_wr_ptr_nxt;
      r_rd_ptr  <= w_rd_ptr_nxt;
      r_half    <= w_half_nxt;
      if (w_wr_acc && !r_half) r_lo_byte <= bus.data;
      r_rdempty <= (w_words_nxt == '0);
      r_wrfull  <= (w_bytes_nxt == BCNT_W'(2 * WORD_DEPTH));
      r_rdusedw <= w_words_nxt;
      r_wrusedw <= w_bytes_nxt;
    end
  end

  sdpram_16 u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_word_wr),
    .i_wr_addr (r_wr_ptr[ADDR_W-1:0]),
    .i_wr_data (w_wr_word),
    .i_rd_en   (w_ram_rd_en),
    .i_rd_addr (w_ram_rd_addr),
    .o_rd_data (w_ram_rd_data)
  );

`ifdef FIFO_SHOWAHEAD_EN
  // RAM prefetches the next head every cycle; a word landing on the head slot is forwarded.
  logic  r_fwd_sel;
  word_t r_fwd_data;
  word_t w_head;

  assign w_ram_rd_en   = 1'b1;
  assign w_ram_rd_addr = w_rd_ptr_nxt[ADDR_W-1:0];
  assign w_head        = r_fwd_sel ? r_fwd_data : w_ram_rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fwd_sel  <= 1'b0;
      r_fwd_data <= '0;
      r_q        <= '0;
    end else begin
      r_fwd_sel  <= w_word_wr && (r_wr_ptr[ADDR_W-1:0] == w_rd_ptr_nxt[ADDR_W-1:0]);
      r_fwd_data <= w_wr_word;
      r_q        <= ((w_words_nxt == '0) || r_rdempty) ? '0 : w_head;
    end
  end
`else
  // RAM read on the accepting edge, q loaded on the following edge.
  logic r_rd_vld;

  assign w_ram_rd_en   = w_rd_acc;
  assign w_ram_rd_addr = r_rd_ptr[ADDR_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_vld <= 1'b0;
      r_q      <= '0;
    end else begin
      r_rd_vld <= w_rd_acc;
      if (r_rd_vld) r_q <= w_ram_rd_data;
    end
  end
`endif

  assign bus.q       = r_q;
  assign bus.rdempty = r_rdempty;
  assign bus.wrfull  = r_wrfull;
  assign bus.rdusedw = r_rdusedw;
  assign bus.wrusedw = r_wrusedw;

endmodule

// File: tb/tb_mywcfifo_8to16.sv
// Self-checking bench for mywcfifo_8to16: byte-queue reference model compared every cycle plus directed literal checks.
module tb_mywcfifo_8to16;
  import mywcfifo_pkg::*;

  localparam int BYTES_MAX = 2 * WORD_DEPTH;

  logic clk;
  logic rst_n;
  logic chk_en;
  int   n_checks;
  int   n_errors;

  mywcfifo_8to16_if bus ();

  mywcfifo_8to16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the FIFO contents as a plain byte queue, oldest byte first.
  byte_t m_bytes[$];
  word_t m_q;
`ifndef FIFO_SHOWAHEAD_EN
  logic  m_pend;
  word_t m_pend_word;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_bytes.delete();
    m_q = '0;
`ifndef FIFO_SHOWAHEAD_EN
    m_pend      = 1'b0;
    m_pend_word = '0;
`endif
  endtask

  task automatic model_edge(input logic wr, input byte_t d, input logic rd);
    int    sz;
    logic  racc;
    logic  wacc;
    word_t head_prev;
    sz        = m_bytes.size();
    racc      = rd && (sz >= 2);
    wacc      = wr && (sz < BYTES_MAX);
    head_prev = '0;
    if (sz >= 2) head_prev = {m_bytes[1], m_bytes[0]};
    if (racc) begin
      void'(m_bytes.pop_front());
      void'(m_bytes.pop_front());
    end
    if (wacc) m_bytes.push_back(d);
`ifdef FIFO_SHOWAHEAD_EN
    m_q = (m_bytes.size() < 2 || sz < 2) ? '0 : head_prev;
`else
    if (m_pend) m_q = m_pend_word;
    m_pend      = racc;
    m_pend_word = head_prev;
`endif
  endtask

  task automatic step(input logic wr, input byte_t d, input logic rd);
    bus.wrreq = wr;
    bus.data  = d;
    bus.rdreq = rd;
    @(posedge clk);
    model_edge(wr, d, rd);
    #1;
    bus.wrreq = 1'b0;
    bus.rdreq = 1'b0;
  endtask

  // Every-cycle comparison against the byte-queue model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("q",       32'(bus.q),       32'(m_q));
      check("rdempty", 32'(bus.rdempty), 32'(m_bytes.size() < 2));
      check("wrfull",  32'(bus.wrfull),  32'(m_bytes.size() == BYTES_MAX));
      check("rdusedw", 32'(bus.rdusedw), 32'(m_bytes.size() / 2));
      check("wrusedw", 32'(bus.wrusedw), 32'(m_bytes.size()));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    chk_en    = 1'b0;
    rst_n     = 1'b1;
    bus.data  = '0;
    bus.wrreq = 1'b0;
    bus.rdreq = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    check("init_rdempty", 32'(bus.rdempty), 32'd1);
    check("init_wrusedw", 32'(bus.wrusedw), 32'd0);
    check("init_q",       32'(bus.q),       32'h0);

`ifdef FIFO_SHOWAHEAD_EN
    step(1'b1, 8'h34, 1'b0);
    step(1'b1, 8'h12, 1'b0);
    check("sa_rdempty_fall", 32'(bus.rdempty), 32'd0);
    step(1'b0, 8'h00, 1'b0);
    check("sa_q_head", 32'(bus.q), 32'h1234);
    step(1'b0, 8'h00, 1'b1);
    check("sa_q_empty",    32'(bus.q),       32'h0);
    check("sa_rdempty_rd", 32'(bus.rdempty), 32'd1);
`endif

    // Reset in the middle of a byte pair discards the pending byte.
    step(1'b1, 8'hA5, 1'b0);
    check("pair_wrusedw", 32'(bus.wrusedw), 32'd1);
    check("pair_rdempty", 32'(bus.rdempty), 32'd1);
    rst_n = 1'b0;
    model_reset();
    #2;
    check("rst_rdempty", 32'(bus.rdempty), 32'd1);
    check("rst_wrfull",  32'(bus.wrfull),  32'd0);
    check("rst_rdusedw", 32'(bus.rdusedw), 32'd0);
    check("rst_wrusedw", 32'(bus.wrusedw), 32'd0);
    check("rst_q",       32'(bus.q),       32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h02, 1'b0);
    step(1'b0, 8'h00, 1'b0);
`ifdef FIFO_SHOWAHEAD_EN
    check("rst_word_sa", 32'(bus.q), 32'h0201);
`endif
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
`ifndef FIFO_SHOWAHEAD_EN
    check("rst_word", 32'(bus.q), 32'h0201);
`endif

    // Fill to 512 bytes, then one write that must be ignored.
    for (int i = 0; i < BYTES_MAX; i++) begin
      step(1'b1, 8'(i), 1'b0);
      check("fill_wrusedw", 32'(bus.wrusedw), 32'(i + 1));
    end
    check("full_rdusedw", 32'(bus.rdusedw), 32'd256);
    check("full_wrfull",  32'(bus.wrfull),  32'd1);
    step(1'b1, 8'hFF, 1'b0);
    check("full_ignore_wrusedw", 32'(bus.wrusedw), 32'd512);

    // Back-to-back drain.
    for (int k = 0; k < WORD_DEPTH; k++) begin
      step(1'b0, 8'h00, 1'b1);
`ifndef FIFO_SHOWAHEAD_EN
      if (k == 1) check("drain_first", 32'(bus.q), 32'h0100);
`endif
    end
    check("drain_rdempty", 32'(bus.rdempty), 32'd1);
    check("drain_rdusedw", 32'(bus.rdusedw), 32'd0);
    step(1'b0, 8'h00, 1'b0);
`ifndef FIFO_SHOWAHEAD_EN
    check("drain_last", 32'(bus.q), 32'hFFFE);
`endif
    step(1'b0, 8'h00, 1'b1);
`ifndef FIFO_SHOWAHEAD_EN
    check("empty_rd_q", 32'(bus.q), 32'hFFFE);
`endif
    check("empty_rd_wrusedw", 32'(bus.wrusedw), 32'd0);

    // Odd byte count: the third byte waits for its partner.
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    check("odd_rdusedw", 32'(bus.rdusedw), 32'd1);
    check("odd_wrusedw", 32'(bus.wrusedw), 32'd3);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
`ifndef FIFO_SHOWAHEAD_EN
    check("odd_q", 32'(bus.q), 32'h2211);
`endif
    check("odd_rdempty", 32'(bus.rdempty), 32'd1);
    check("odd_wrusedw_after", 32'(bus.wrusedw), 32'd1);
    step(1'b1, 8'h44, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
`ifndef FIFO_SHOWAHEAD_EN
    check("odd_pair_q", 32'(bus.q), 32'h4433);
`endif

    // Ten words stored, then a byte pair written while two words are read.
    for (int i = 0; i < 20; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
    check("sim_rdusedw_pre", 32'(bus.rdusedw), 32'd10);
    step(1'b1, 8'hA0, 1'b1);
    step(1'b1, 8'hA1, 1'b1);
    check("sim_rdusedw", 32'(bus.rdusedw), 32'd9);
    check("sim_wrusedw", 32'(bus.wrusedw), 32'd18);
`ifndef FIFO_SHOWAHEAD_EN
    check("sim_q_first", 32'(bus.q), 32'h4140);
`endif
    for (int i = 0; i < 9; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
`ifndef FIFO_SHOWAHEAD_EN
    check("sim_q_last", 32'(bus.q), 32'hA1A0);
`endif
    check("sim_rdempty", 32'(bus.rdempty), 32'd1);

    // At full, a simultaneous write and read accepts only the read.
    for (int i = 0; i < BYTES_MAX; i++) step(1'b1, 8'(i), 1'b0);
    check("full2_wrfull", 32'(bus.wrfull), 32'd1);
    step(1'b1, 8'hEE, 1'b1);
    check("fullrw_rdusedw", 32'(bus.rdusedw), 32'd255);
    check("fullrw_wrusedw", 32'(bus.wrusedw), 32'd510);
    check("fullrw_wrfull",  32'(bus.wrfull),  32'd0);
    step(1'b0, 8'h00, 1'b0);
`ifndef FIFO_SHOWAHEAD_EN
    check("fullrw_q", 32'(bus.q), 32'h0100);
`endif

    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
